// File: rtl/agnus_blitter_adrseq_if.sv
// rtl/agnus_blitter_adrseq_if.sv - register bus, sequencer controls and address outputs of the blitter address generator
interface agnus_blitter_adrseq_if #(
    parameter int ADDR_W = 21
);
    // Register bus: a write happens whenever reg_address_in matches a register.
    logic [8:1]      reg_address_in;
    logic [15:0]     data_in;

    // DMA slot controls
    logic            step;
    logic [1:0]      chsel;
    logic            desc;
    logic            adv;

    // Address and sequencer status
    logic [ADDR_W:1] address_out;
    logic            sign_out;
    logic            busy;
    logic            first_word;
    logic            last_word;
    logic            done;

    modport master (
        output reg_address_in, data_in, step, chsel, desc, adv,
        input  address_out, sign_out, busy, first_word, last_word, done
    );

    modport slave (
        input  reg_address_in, data_in, step, chsel, desc, adv,
        output address_out, sign_out, busy, first_word, last_word, done
    );
endinterface

// File: rtl/agnus_blitter_adrseq.sv
// rtl/agnus_blitter_adrseq.sv - four-channel blitter pointer/modulo generator with built-in word/row sequencer
module agnus_blitter_adrseq #(
    parameter int ADDR_W = 21,
    parameter int HW     = 11,
    parameter int VW     = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk7_en,
    agnus_blitter_adrseq_if.slave  bus
);

    // Register addresses in reg_address_in[8:1] units (byte address >> 1).
    localparam logic [8:1] ADR_PTH_C = 8'h24;   // 048, channels follow every 4 bytes
    localparam logic [8:1] ADR_PTL_C = 8'h25;   // 04A
    localparam logic [8:1] ADR_MOD_C = 8'h30;   // 060, channels follow every 2 bytes
    localparam logic [8:1] ADR_SIZE  = 8'h2C;   // 058
    localparam logic [8:1] ADR_SIZV  = 8'h2E;   // 05C
    localparam logic [8:1] ADR_SIZH  = 8'h2F;   // 05E

    localparam logic [ADDR_W:1] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [HW:0]     W_ONE   = {{HW{1'b0}}, 1'b1};
    localparam logic [VW:0]     V_ONE   = {{VW{1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              done_q, done_d;

    // Channel storage is indexed directly by chsel: 0=C 1=B 2=A 3=D.
    logic [ADDR_W:1]   ptr_q [4];
    logic [ADDR_W:1]   ptr_d [4];
    logic [15:1]       mod_q [4];
    logic [15:1]       mod_d [4];

    // Latched size registers in raw form (0 = maximum count).
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [HW:0]       wcnt_q, wcnt_d;
    logic [VW:0]       hcnt_q, hcnt_d;

    logic [3:0]        wr_pth, wr_ptl, wr_mod;
    logic              wr_size, wr_sizv, wr_sizh;
    logic              start_c, adv_c, final_c;
    logic              last_word_c;
    logic [HW:0]       h_eff;
    logic [ADDR_W:1]   a_next;

    // Expand a raw size field to a count, where 0 means 2**width.
    function automatic logic [HW:0] w_eff(input logic [HW-1:0] raw);
        return (raw == '0) ? {1'b1, {HW{1'b0}}} : {1'b0, raw};
    endfunction

    function automatic logic [VW:0] v_eff(input logic [VW-1:0] raw);
        return (raw == '0) ? {1'b1, {VW{1'b0}}} : {1'b0, raw};
    endfunction

    // One-word pointer step, with the sign-extended modulo folded in on the last word of a row.
    function automatic logic [ADDR_W:1] step_value(
        input logic [ADDR_W:1] p,
        input logic [15:1]     m,
        input logic            dn,
        input logic            apply_mod
    );
        logic [ADDR_W:1] modx;
        logic [ADDR_W:1] r;
        modx = {{(ADDR_W-15){m[15]}}, m};
        r    = dn ? (p - PTR_ONE) : (p + PTR_ONE);
        if (apply_mod) begin
            r = dn ? (r - modx) : (r + modx);
        end
        return r;
    endfunction

    // Register address decode.
    always_comb begin
        for (int ch = 0; ch < 4; ch++) begin
            wr_pth[ch] = (bus.reg_address_in == ADR_PTH_C + {5'd0, 2'(ch), 1'b0});
            wr_ptl[ch] = (bus.reg_address_in == ADR_PTL_C + {5'd0, 2'(ch), 1'b0});
            wr_mod[ch] = (bus.reg_address_in == ADR_MOD_C + {6'd0, 2'(ch)});
        end
        wr_size = (bus.reg_address_in == ADR_SIZE);
        wr_sizv = (bus.reg_address_in == ADR_SIZV);
        wr_sizh = (bus.reg_address_in == ADR_SIZH);
    end

    // Pointer/modulo next state: register writes first, then a step on the same channel overrides them.
    always_comb begin
        for (int ch = 0; ch < 4; ch++) begin
            ptr_d[ch] = ptr_q[ch];
            if (wr_pth[ch]) begin
                ptr_d[ch][ADDR_W:16] = bus.data_in[ADDR_W-16:0];
            end
            if (wr_ptl[ch]) begin
                ptr_d[ch][15:1] = bus.data_in[15:1];
            end
            if (bus.step && (bus.chsel == 2'(ch))) begin
                ptr_d[ch] = step_value(ptr_q[ch], mod_q[ch], bus.desc, last_word_c);
            end
            mod_d[ch] = wr_mod[ch] ? bus.data_in[15:1] : mod_q[ch];
        end
    end

    // Size latches and word/row counters; sizes are frozen while a blit runs.
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        wcnt_d  = wcnt_q;
        hcnt_d  = hcnt_q;
        start_c = 1'b0;
        if (state_q == S_IDLE) begin
            if (wr_size) begin
                h_d = (bus.data_in[5:0] == 6'd0)  ? HW'(7'd64)    : HW'(bus.data_in[5:0]);
                v_d = (bus.data_in[15:6] == 10'd0) ? VW'(11'd1024) : VW'(bus.data_in[15:6]);
            end
            if (wr_sizv) begin
                v_d = bus.data_in[VW-1:0];
            end
            if (wr_sizh) begin
                h_d = bus.data_in[HW-1:0];
            end
            start_c = wr_size || wr_sizh;
            if (start_c) begin
                wcnt_d = w_eff(h_d);
                hcnt_d = v_eff(v_d);
            end
        end else if (adv_c) begin
            if (wcnt_q == W_ONE) begin
                wcnt_d = h_eff;
                if (hcnt_q != V_ONE) begin
                    hcnt_d = hcnt_q - V_ONE;
                end
            end else begin
                wcnt_d = wcnt_q - W_ONE;
            end
        end
    end

    assign h_eff   = w_eff(h_q);
    assign adv_c   = (state_q == S_RUN) && bus.adv;
    assign final_c = adv_c && (wcnt_q == W_ONE) && (hcnt_q == V_ONE);

    // Datapath registers, enabled by clk7_en.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                for (int ch = 0; ch < 4; ch++) begin
                    ptr_q[ch] <= '0;
                    mod_q[ch] <= '0;
                end
                h_q    <= '0;
                v_q    <= '0;
                wcnt_q <= '0;
                hcnt_q <= '0;
            end else begin
                for (int ch = 0; ch < 4; ch++) begin
                    ptr_q[ch] <= ptr_d[ch];
                    mod_q[ch] <= mod_d[ch];
                end
                h_q    <= h_d;
                v_q    <= v_d;
                wcnt_q <= wcnt_d;
                hcnt_q <= hcnt_d;
            end
        end
    end

    // Sequencer state register and the registered done pulse.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                state_q <= S_IDLE;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                done_q  <= done_d;
            end
        end
    end

    // Sequencer next state: a size write starts a blit, the final advance of the last row ends it.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (final_c) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // Outputs: sequencer status, selected pointer and channel A's line-mode sign.
    always_comb begin
        last_word_c     = (state_q == S_RUN) && (wcnt_q == W_ONE);
        a_next          = step_value(ptr_q[2], mod_q[2], bus.desc, last_word_c);
        bus.busy        = (state_q == S_RUN);
        bus.first_word  = (state_q == S_RUN) && (wcnt_q == h_eff);
        bus.last_word   = last_word_c;
        bus.done        = done_q;
        bus.address_out = ptr_q[bus.chsel];
        bus.sign_out    = a_next[15];
    end

endmodule

// File: tb/tb_agnus_blitter_adrseq.sv
// tb/tb_agnus_blitter_adrseq.sv - directed and randomized check of the blitter address generator against a behavioural model
module tb_agnus_blitter_adrseq;
    localparam int ADDR_W = 21;
    localparam int HW     = 11;
    localparam int VW     = 15;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    localparam logic [8:0] R_IDLE = 9'h1FE;
    localparam logic [8:0] R_APTH = 9'h050;
    localparam logic [8:0] R_APTL = 9'h052;
    localparam logic [8:0] R_BPTH = 9'h04C;
    localparam logic [8:0] R_BPTL = 9'h04E;
    localparam logic [8:0] R_DPTH = 9'h054;
    localparam logic [8:0] R_DPTL = 9'h056;
    localparam logic [8:0] R_AMOD = 9'h064;
    localparam logic [8:0] R_DMOD = 9'h066;
    localparam logic [8:0] R_SIZE = 9'h058;
    localparam logic [8:0] R_SIZV = 9'h05C;
    localparam logic [8:0] R_SIZH = 9'h05E;
    localparam logic [1:0] CH_A = 2'b10;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b00;
    localparam logic [1:0] CH_D = 2'b11;

    logic clk = 1'b0;
    logic reset;
    logic clk7_en;

    agnus_blitter_adrseq_if #(.ADDR_W(ADDR_W)) bus ();

    agnus_blitter_adrseq #(.ADDR_W(ADDR_W), .HW(HW), .VW(VW)) dut (
        .clk     (clk),
        .reset   (reset),
        .clk7_en (clk7_en),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: pointers as word addresses, blit progress as a count of advances.
    int m_ptr [4];
    int m_mod [4];
    int m_hl, m_vl, m_h, m_v, m_k;
    bit m_run, m_done;

    int dexp [6] = '{'h101, 'h102, 'h0FF, 'h100, 'h101, 'h0FE};
    logic [8:0] rtab [15] = '{9'h048, 9'h04A, 9'h04C, 9'h04E, 9'h050, 9'h052, 9'h054, 9'h056,
                              9'h060, 9'h062, 9'h064, 9'h066, 9'h058, 9'h05C, 9'h05E};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic int stepval(int p, int m, bit ds, bit last);
        int r;
        r = ds ? p - 1 : p + 1;
        if (last) r = ds ? r - m : r + m;
        return r & AMASK;
    endfunction

    function automatic bit m_last();
        if (!m_run) return 1'b0;
        return (m_k % m_h) == (m_h - 1);
    endfunction

    function automatic bit m_first();
        if (!m_run) return 1'b0;
        return (m_k % m_h) == 0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_ptr[c] = 0;
            m_mod[c] = 0;
        end
        m_hl = 0; m_vl = 0; m_h = 0; m_v = 0; m_k = 0;
        m_run = 1'b0; m_done = 1'b0;
    endfunction

    function automatic void start_blit();
        m_h   = (m_hl == 0) ? 2048 : m_hl;
        m_v   = (m_vl == 0) ? 32768 : m_vl;
        m_k   = 0;
        m_run = 1'b1;
    endfunction

    // Apply one enabled clock edge to the model using the inputs present at that edge.
    function automatic void model_edge();
        int  byte_a, d, ch, sv;
        bit  last, was_run;
        if (!clk7_en) return;
        if (reset) begin
            model_reset();
            return;
        end
        last    = m_last();
        was_run = m_run;
        byte_a  = int'({bus.reg_address_in, 1'b0});
        d       = int'(bus.data_in);
        ch      = int'(bus.chsel);
        sv      = stepval(m_ptr[ch], m_mod[ch], bus.desc, last);
        for (int c = 0; c < 4; c++) begin
            if (byte_a == 'h48 + 4 * c) m_ptr[c] = (m_ptr[c] & 'h7FFF) | ((d & 'h3F) << 15);
            if (byte_a == 'h4A + 4 * c) m_ptr[c] = (m_ptr[c] & ~'h7FFF & AMASK) | ((d >> 1) & 'h7FFF);
            if (byte_a == 'h60 + 2 * c) begin
                m_mod[c] = (d >> 1) & 'h7FFF;
                if (m_mod[c] >= 'h4000) m_mod[c] -= 'h8000;
            end
        end
        if (bus.step) m_ptr[ch] = sv;
        m_done = 1'b0;
        if (was_run && bus.adv) begin
            m_k++;
            if (m_k == m_h * m_v) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end
        if (!was_run) begin
            if (byte_a == 'h58) begin
                m_hl = ((d & 'h3F) == 0) ? 64 : (d & 'h3F);
                m_vl = ((d >> 6) == 0) ? 1024 : (d >> 6);
                start_blit();
            end else if (byte_a == 'h5C) begin
                m_vl = d & 'h7FFF;
            end else if (byte_a == 'h5E) begin
                m_hl = d & 'h7FF;
                start_blit();
            end
        end
    endfunction

    task automatic check_outputs();
        int sv;
        sv = stepval(m_ptr[2], m_mod[2], bus.desc, m_last());
        check("address_out", 32'(bus.address_out), m_ptr[bus.chsel]);
        check("busy",        32'(bus.busy),        32'(m_run));
        check("first_word",  32'(bus.first_word),  32'(m_first()));
        check("last_word",   32'(bus.last_word),   32'(m_last()));
        check("done",        32'(bus.done),        32'(m_done));
        check("sign_out",    32'(bus.sign_out),    (sv >> 14) & 1);
    endtask

    task automatic cyc(input logic [8:0] a, input logic [15:0] d, input logic st,
                       input logic [1:0] cs, input logic ds, input logic ad);
        bus.reg_address_in = a[8:1];
        bus.data_in        = d;
        bus.step           = st;
        bus.chsel          = cs;
        bus.desc           = ds;
        bus.adv            = ad;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  seen;
        logic [8:0]  ra;
        logic [15:0] rd;

        model_reset();
        reset   = 1'b1;
        clk7_en = 1'b1;
        cyc(R_IDLE, 16'h0, 1'b0, CH_A, 1'b0, 1'b0);
        reset = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        for (int c = 0; c < 4; c++) cyc(R_IDLE, 16'h0, 1'b0, 2'(c), 1'b0, 1'b0);

        // All-ones pointer wraps to zero; a narrower high half carries normally.
        cyc(R_APTH, 16'h003F, 1'b0, CH_A, 1'b0, 1'b0);
        cyc(R_APTL, 16'hFFFE, 1'b0, CH_A, 1'b0, 1'b0);
        check("a_all_ones", 32'(bus.address_out), 32'h1FFFFF);
        cyc(R_IDLE, 16'h0, 1'b1, CH_A, 1'b0, 1'b0);
        check("a_wrap", 32'(bus.address_out), 32'h0);
        cyc(R_APTH, 16'h001F, 1'b0, CH_A, 1'b0, 1'b0);
        cyc(R_APTL, 16'hFFFE, 1'b0, CH_A, 1'b0, 1'b0);
        check("a_half_ones", 32'(bus.address_out), 32'h0FFFFF);
        cyc(R_IDLE, 16'h0, 1'b1, CH_A, 1'b0, 1'b0);
        check("a_carry", 32'(bus.address_out), 32'h100000);

        // Channel D, 3 words x 2 rows, modulo -4 words.
        cyc(R_DMOD, 16'hFFF8, 1'b0, CH_D, 1'b0, 1'b0);
        cyc(R_DPTH, 16'h0000, 1'b0, CH_D, 1'b0, 1'b0);
        cyc(R_DPTL, 16'h0200, 1'b0, CH_D, 1'b0, 1'b0);
        cyc(R_SIZV, 16'h0002, 1'b0, CH_D, 1'b0, 1'b0);
        cyc(R_SIZH, 16'h0003, 1'b0, CH_D, 1'b0, 1'b0);
        check("d_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cyc(R_IDLE, 16'h0, 1'b1, CH_D, 1'b0, 1'b1);
            check("d_seq", 32'(bus.address_out), dexp[i]);
            check("d_done", 32'(bus.done), (i == 5) ? 32'd1 : 32'd0);
        end
        check("d_idle", 32'(bus.busy), 32'd0);
        cyc(R_IDLE, 16'h0, 1'b0, CH_D, 1'b0, 1'b0);
        check("d_done_clear", 32'(bus.done), 32'd0);

        // Channel A descending, 2 words x 1 row, modulo 2.
        cyc(R_AMOD, 16'h0004, 1'b0, CH_A, 1'b1, 1'b0);
        cyc(R_APTH, 16'h0000, 1'b0, CH_A, 1'b1, 1'b0);
        cyc(R_APTL, 16'h00A0, 1'b0, CH_A, 1'b1, 1'b0);
        cyc(R_SIZE, 16'h0042, 1'b0, CH_A, 1'b1, 1'b0);
        cyc(R_IDLE, 16'h0, 1'b1, CH_A, 1'b1, 1'b1);
        check("a_desc_0", 32'(bus.address_out), 32'h4F);
        cyc(R_IDLE, 16'h0, 1'b1, CH_A, 1'b1, 1'b1);
        check("a_desc_1", 32'(bus.address_out), 32'h4C);
        check("a_desc_done", 32'(bus.done), 32'd1);

        // Step beats a simultaneous low-half write on the same channel.
        cyc(R_BPTH, 16'h0000, 1'b0, CH_B, 1'b0, 1'b0);
        cyc(R_BPTL, 16'h2468, 1'b0, CH_B, 1'b0, 1'b0);
        cyc(R_BPTL, 16'h0200, 1'b1, CH_B, 1'b0, 1'b0);
        check("b_step_wins", 32'(bus.address_out), 32'h1235);

        // Maximum BLTSIZE: 64 x 1024 advances; a size write mid-run is ignored.
        cyc(R_SIZE, 16'h0000, 1'b0, CH_C, 1'b0, 1'b0);
        check("max_first", 32'(bus.first_word), 32'd1);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 70000 && !seen; i++) begin
            cyc((i == 100) ? R_SIZE : R_IDLE, 16'h0041, 1'b0, CH_C, 1'b0, 1'b1);
            n++;
            if (bus.done) seen = 1'b1;
        end
        check("max_adv_count", n, 65536);

        // Reset in the middle of a blit aborts it without a done pulse.
        cyc(R_SIZE, 16'h0104, 1'b0, CH_C, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(R_IDLE, 16'h0, 1'b1, CH_C, 1'b0, 1'b1);
        reset = 1'b1;
        cyc(R_IDLE, 16'h0, 1'b0, CH_C, 1'b0, 1'b1);
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        for (int c = 0; c < 4; c++) begin
            cyc(R_IDLE, 16'h0, 1'b0, 2'(c), 1'b0, 1'b1);
            check("abort_ptr", 32'(bus.address_out), 32'd0);
        end

        // Randomized traffic, including disabled clock-enable cycles and occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ra = R_IDLE;
                rd = 16'($urandom);
            end else begin
                ra = rtab[$urandom_range(0, 14)];
                rd = 16'($urandom);
                if (ra == R_SIZE) rd = 16'(($urandom_range(1, 2) << 6) | $urandom_range(0, 3));
                if (ra == R_SIZV || ra == R_SIZH) rd = 16'($urandom_range(1, 3));
            end
            clk7_en = ($urandom_range(0, 7) != 0);
            reset   = ($urandom_range(0, 99) == 0);
            cyc(ra, rd, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        reset   = 1'b0;
        clk7_en = 1'b1;
        cyc(R_IDLE, 16'h0, 1'b0, CH_A, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
